dbi_tx_sequencer: RTL and testbench

Parametrised successor to the DBI transmit FSM in the display TX controller. It sits between the AXI4 configuration register / pixel FIFO and the DBI TX PHY, and issues configuration transactions and memory-write pixel streams. It adds:
- multi-byte pixel serialisation (PXL_BYTES beats per pixel, MSB first);
- a run-time frame length instead of a fixed transaction size;
- a parametrised hardware-reset stall;
- an optional sleep-out stall.

---
 rtl/dbi_tx_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dbi_tx_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbi_tx_sequencer.sv
// DBI TX sequencer: issues config transactions and serialised pixel streams to the DBI PHY.
// Define DBI_TX_SLP_STALL_EN to compile in the stall that follows a sleep-out command.
module dbi_tx_sequencer #(
    parameter int unsigned           INTERNAL_CLK = 125000000,
    parameter int                    DBI_IF_D_W   = 8,
    parameter int                    PXL_BYTES    = 2,
    parameter int                    FRAME_CNT_W  = 18,
    parameter int                    DAT_AMT_W    = 3,
    parameter int unsigned           RST_STALL_MS = 120,
    parameter int unsigned           SLP_STALL_MS = 6,
    parameter logic [DBI_IF_D_W-1:0] SLPOUT_CMD   = DBI_IF_D_W'(8'h11)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        dbi_ctrl_mode_i,
    input  logic [DBI_IF_D_W-1:0]             dbi_mem_com_i,
    input  logic [FRAME_CNT_W-1:0]            frame_pxl_i,
    input  logic                              tx_type_hrst_i,
    input  logic [DAT_AMT_W-1:0]              tx_type_dat_amt_i,
    input  logic                              tx_type_vld_i,
    output logic                              tx_type_rdy_o,
    input  logic [DBI_IF_D_W-1:0]             tx_com_i,
    input  logic                              tx_com_vld_i,
    output logic                              tx_com_rdy_o,
    input  logic [DBI_IF_D_W-1:0]             tx_data_i,
    input  logic                              tx_data_vld_i,
    output logic                              tx_data_rdy_o,
    input  logic [PXL_BYTES*DBI_IF_D_W-1:0]   pxl_d_i,
    input  logic                              pxl_vld_i,
    output logic                              pxl_rdy_o,
    input  logic                              dtp_tx_rdy_i,
    output logic                              dtp_dbi_hrst_o,
    output logic [DBI_IF_D_W-1:0]             dtp_tx_cmd_typ_o,
    output logic [DBI_IF_D_W-1:0]             dtp_tx_cmd_dat_o,
    output logic                              dtp_tx_last_o,
    output logic                              dtp_tx_no_dat_o,
    output logic                              dtp_tx_vld_o,
    output logic                              busy_o,
    output logic                              frame_done_o
);
    localparam int unsigned RST_CYC = INTERNAL_CLK / 1000 * RST_STALL_MS;
`ifdef DBI_TX_SLP_STALL_EN
    localparam int unsigned SLP_CYC = INTERNAL_CLK / 1000 * SLP_STALL_MS;
    localparam int unsigned MAX_CYC = (RST_CYC > SLP_CYC) ? RST_CYC : SLP_CYC;
`else
    localparam int unsigned MAX_CYC = RST_CYC;
`endif
    localparam int STL_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int CNT_W = FRAME_CNT_W + 2;
    localparam int IDX_W = (PXL_BYTES > 1) ? $clog2(PXL_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CONF_TX,
        STREAM_TX,
        RST_STALL
`ifdef DBI_TX_SLP_STALL_EN
        , SLP_STALL
`endif
    } state_t;

    state_t            state, nxt;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [STL_W-1:0]  stl;
    logic              frame_done;
    logic              beat_ok;

    assign beat_ok      = dtp_tx_vld_o & dtp_tx_rdy_i;
    assign busy_o       = (state != IDLE);
    assign frame_done_o = frame_done;

    always_comb begin
        nxt              = state;
        dtp_dbi_hrst_o   = 1'b0;
        dtp_tx_cmd_typ_o = '0;
        dtp_tx_cmd_dat_o = '0;
        dtp_tx_last_o    = 1'b0;
        dtp_tx_no_dat_o  = 1'b0;
        dtp_tx_vld_o     = 1'b0;
        tx_type_rdy_o    = 1'b0;
        tx_com_rdy_o     = 1'b0;
        tx_data_rdy_o    = 1'b0;
        pxl_rdy_o        = 1'b0;
        case (state)
            IDLE: begin
                if (dbi_ctrl_mode_i == 2'd1 && tx_type_vld_i)
                    nxt = CONF_TX;
                else if (dbi_ctrl_mode_i == 2'd2 && pxl_vld_i && frame_pxl_i != '0)
                    nxt = STREAM_TX;
            end
            CONF_TX: begin
                dtp_tx_no_dat_o  = (tx_type_dat_amt_i == '0);
                dtp_dbi_hrst_o   = tx_type_hrst_i;
                dtp_tx_cmd_typ_o = tx_com_i;
                dtp_tx_cmd_dat_o = tx_data_i;
                dtp_tx_vld_o     = tx_type_vld_i & (tx_type_hrst_i |
                                   (tx_com_vld_i & (dtp_tx_no_dat_o | tx_data_vld_i)));
                dtp_tx_last_o    = (cnt == '0) | tx_type_hrst_i | dtp_tx_no_dat_o;
                tx_type_rdy_o    = beat_ok & dtp_tx_last_o;
                tx_com_rdy_o     = tx_type_rdy_o & ~tx_type_hrst_i;
                tx_data_rdy_o    = beat_ok & ~dtp_tx_no_dat_o & ~tx_type_hrst_i;
                if (tx_type_rdy_o) begin
                    nxt = IDLE;
`ifdef DBI_TX_SLP_STALL_EN
                    if (tx_com_i == SLPOUT_CMD) nxt = SLP_STALL;
`endif
                    // reset stall takes priority over sleep-out
                    if (tx_type_hrst_i) nxt = RST_STALL;
                end
            end
            STREAM_TX: begin
                dtp_tx_cmd_typ_o = dbi_mem_com_i;
                dtp_tx_cmd_dat_o = pxl_d_i[int'(idx)*DBI_IF_D_W +: DBI_IF_D_W];
                dtp_tx_vld_o     = pxl_vld_i;
                dtp_tx_last_o    = (cnt == '0);
                pxl_rdy_o        = beat_ok & (idx == '0);
                if (beat_ok && dtp_tx_last_o) nxt = IDLE;
            end
            RST_STALL: if (stl == '0) nxt = IDLE;
`ifdef DBI_TX_SLP_STALL_EN
            SLP_STALL: if (stl == '0) nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            stl        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (nxt == CONF_TX) begin
                        cnt <= CNT_W'(tx_type_dat_amt_i) - 1'b1;
                    end else if (nxt == STREAM_TX) begin
                        // frame length latched here; later changes on frame_pxl_i are ignored
                        cnt <= CNT_W'(frame_pxl_i) * CNT_W'(PXL_BYTES) - 1'b1;
                        idx <= IDX_W'(PXL_BYTES - 1);
                    end
                end
                CONF_TX: begin
                    if (beat_ok) cnt <= cnt - 1'b1;
                    if (tx_type_rdy_o) begin
                        stl <= STL_W'(RST_CYC - 1);
`ifdef DBI_TX_SLP_STALL_EN
                        if (!tx_type_hrst_i) stl <= STL_W'(SLP_CYC - 1);
`endif
                    end
                end
                STREAM_TX: begin
                    if (beat_ok) begin
                        cnt <= cnt - 1'b1;
                        idx <= (idx == '0) ? IDX_W'(PXL_BYTES - 1) : idx - 1'b1;
                        if (dtp_tx_last_o) frame_done <= 1'b1;
                    end
                end
                default: begin
                    if (stl != '0) stl <= stl - 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dbi_tx_sequencer.sv
// Scoreboard bench for dbi_tx_sequencer: drivers push expected PHY beats, a monitor pops them.
// Works with or without DBI_TX_SLP_STALL_EN defined.
`timescale 1ns/1ps
module tb_dbi_tx_sequencer;
    localparam int W  = 8;
    localparam int PB = 2;
    localparam int FW = 18;
    localparam int AW = 3;
    localparam int CLK_HZ  = 10000;
    localparam int RST_CYC = CLK_HZ / 1000 * 2;
`ifdef DBI_TX_SLP_STALL_EN
    localparam int SLP_CYC = CLK_HZ / 1000 * 6;
`else
    localparam int SLP_CYC = 0;
`endif

    logic clk = 1'b0, rst;
    logic [1:0] dbi_ctrl_mode_i;
    logic [W-1:0] dbi_mem_com_i, tx_com_i, tx_data_i;
    logic [FW-1:0] frame_pxl_i;
    logic tx_type_hrst_i, tx_type_vld_i, tx_com_vld_i, tx_data_vld_i, pxl_vld_i, dtp_tx_rdy_i;
    logic [AW-1:0] tx_type_dat_amt_i;
    logic [PB*W-1:0] pxl_d_i;
    logic tx_type_rdy_o, tx_com_rdy_o, tx_data_rdy_o, pxl_rdy_o;
    logic dtp_dbi_hrst_o, dtp_tx_last_o, dtp_tx_no_dat_o, dtp_tx_vld_o, busy_o, frame_done_o;
    logic [W-1:0] dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o;

    dbi_tx_sequencer #(
        .INTERNAL_CLK(CLK_HZ), .DBI_IF_D_W(W), .PXL_BYTES(PB), .FRAME_CNT_W(FW),
        .DAT_AMT_W(AW), .RST_STALL_MS(2), .SLP_STALL_MS(6), .SLPOUT_CMD(8'h11)
    ) dut (
        .clk(clk), .rst(rst), .dbi_ctrl_mode_i(dbi_ctrl_mode_i), .dbi_mem_com_i(dbi_mem_com_i),
        .frame_pxl_i(frame_pxl_i), .tx_type_hrst_i(tx_type_hrst_i), .tx_type_dat_amt_i(tx_type_dat_amt_i),
        .tx_type_vld_i(tx_type_vld_i), .tx_type_rdy_o(tx_type_rdy_o), .tx_com_i(tx_com_i),
        .tx_com_vld_i(tx_com_vld_i), .tx_com_rdy_o(tx_com_rdy_o), .tx_data_i(tx_data_i),
        .tx_data_vld_i(tx_data_vld_i), .tx_data_rdy_o(tx_data_rdy_o), .pxl_d_i(pxl_d_i),
        .pxl_vld_i(pxl_vld_i), .pxl_rdy_o(pxl_rdy_o), .dtp_tx_rdy_i(dtp_tx_rdy_i),
        .dtp_dbi_hrst_o(dtp_dbi_hrst_o), .dtp_tx_cmd_typ_o(dtp_tx_cmd_typ_o),
        .dtp_tx_cmd_dat_o(dtp_tx_cmd_dat_o), .dtp_tx_last_o(dtp_tx_last_o),
        .dtp_tx_no_dat_o(dtp_tx_no_dat_o), .dtp_tx_vld_o(dtp_tx_vld_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         hrst;
        logic [W-1:0] typ;
        logic [W-1:0] dat;
        logic         last;
        logic         no_dat;
        logic         strm;
    } beat_t;

    beat_t sb[$];
    int tests = 0, fails = 0;
    bit force_rdy = 1'b0;
    bit fd_pend = 1'b0;
    logic [W-1:0] cdat [8];
    logic [PB*W-1:0] pix [16];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic logic [25:0] outs();
        return {busy_o, frame_done_o, dtp_tx_vld_o, dtp_dbi_hrst_o, dtp_tx_last_o, dtp_tx_no_dat_o,
                dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, tx_type_rdy_o, tx_com_rdy_o, tx_data_rdy_o, pxl_rdy_o};
    endfunction

    // PHY back-pressure
    initial begin
        dtp_tx_rdy_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            dtp_tx_rdy_i = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: pops one expectation per accepted beat and checks the frame_done pulse
    always @(negedge clk) begin
        beat_t e;
        if (fd_pend || frame_done_o) begin
            tests++;
            if (frame_done_o !== fd_pend) begin
                fails++;
                $display("FAIL frame_done got %0b want %0b", frame_done_o, fd_pend);
            end
        end
        fd_pend = 1'b0;
        if (dtp_tx_vld_o && dtp_tx_rdy_i) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected got typ %h dat %h last %0b", dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, dtp_tx_last_o);
            end else begin
                e = sb.pop_front();
                if ({dtp_dbi_hrst_o, dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, dtp_tx_last_o, dtp_tx_no_dat_o} !==
                    {e.hrst, e.typ, e.dat, e.last, e.no_dat}) begin
                    fails++;
                    $display("FAIL beat got h%0b typ %h dat %h l%0b n%0b want h%0b typ %h dat %h l%0b n%0b",
                             dtp_dbi_hrst_o, dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, dtp_tx_last_o, dtp_tx_no_dat_o,
                             e.hrst, e.typ, e.dat, e.last, e.no_dat);
                end
                if (e.strm && e.last) fd_pend = 1'b1;
            end
        end
    end

    task automatic do_conf(input bit hrst, input int amt, input logic [W-1:0] com);
        beat_t e;
        int k = 0, dc = 0, cc = 0, cyc = 0, stall = 0, quiet_bad = 0, want;
        bit tr = 1'b0, dr, cr;
        if (hrst || amt == 0) begin
            e.hrst = hrst; e.typ = com; e.dat = '0; e.last = 1'b1; e.no_dat = (amt == 0); e.strm = 1'b0;
            sb.push_back(e);
        end else begin
            for (int i = 0; i < amt; i++) begin
                e.hrst = 1'b0; e.typ = com; e.dat = cdat[i]; e.last = (i == amt - 1); e.no_dat = 1'b0; e.strm = 1'b0;
                sb.push_back(e);
            end
        end
        dbi_ctrl_mode_i = 2'd1; tx_type_hrst_i = hrst; tx_type_dat_amt_i = AW'(amt); tx_type_vld_i = 1'b1;
        tx_com_i = com; tx_com_vld_i = 1'b1;
        tx_data_i = (hrst || amt == 0) ? '0 : cdat[0];
        tx_data_vld_i = !(hrst || amt == 0) && ($urandom_range(0, 1) == 1);
        while (!tr && cyc < 400) begin
            @(negedge clk);
            tr = tx_type_rdy_o; dr = tx_data_rdy_o; cr = tx_com_rdy_o;
            @(posedge clk); #1;
            cyc++;
            if (cr) cc++;
            if (dr) begin
                dc++; k++;
                tx_data_i = (k < amt) ? cdat[k] : '0;
                tx_data_vld_i = (k < amt) && ($urandom_range(0, 1) == 1);
            end else if (!hrst && k < amt && !tx_data_vld_i) begin
                tx_data_vld_i = ($urandom_range(0, 1) == 1);
            end
        end
        if (!tr) begin
            tests++; fails++;
            $display("FAIL conf_timeout got no type_rdy want type_rdy within 400 cycles");
        end
        chk("conf_data_rdy_count", 64'(dc), hrst ? 64'd0 : 64'(amt));
        chk("conf_com_rdy_count", 64'(cc), hrst ? 64'd0 : 64'd1);
        // hold upstream valids so any leak during the stall is visible
        dbi_ctrl_mode_i = 2'd0; pxl_vld_i = 1'b1;
        want = hrst ? RST_CYC : ((com == 8'h11) ? SLP_CYC : 0);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!busy_o) break;
            stall++;
            if ({dtp_tx_vld_o, tx_type_rdy_o, tx_com_rdy_o, tx_data_rdy_o, pxl_rdy_o,
                 dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o} != '0) quiet_bad++;
        end
        chk("stall_len", 64'(stall), 64'(want));
        chk("stall_quiet", 64'(quiet_bad), 64'd0);
        tx_type_vld_i = 1'b0; tx_com_vld_i = 1'b0; tx_data_vld_i = 1'b0; pxl_vld_i = 1'b0; tx_type_hrst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_stream(input int np);
        beat_t e;
        int pi = 0, cyc = 0;
        bit pr;
        logic [W-1:0] mc = W'($urandom);
        for (int p = 0; p < np; p++)
            for (int b = PB - 1; b >= 0; b--) begin
                e.hrst = 1'b0; e.typ = mc; e.dat = pix[p][b*W +: W];
                e.last = (p == np - 1) && (b == 0); e.no_dat = 1'b0; e.strm = 1'b1;
                sb.push_back(e);
            end
        dbi_mem_com_i = mc; frame_pxl_i = FW'(np); pxl_d_i = pix[0]; pxl_vld_i = 1'b1; dbi_ctrl_mode_i = 2'd2;
        while (pi < np && cyc < 400) begin
            @(negedge clk);
            pr = pxl_rdy_o;
            @(posedge clk); #1;
            cyc++;
            if (pr) begin
                pi++;
                frame_pxl_i = FW'($urandom);
                dbi_ctrl_mode_i = 2'($urandom_range(0, 3));
                if (pi < np) begin
                    pxl_d_i = pix[pi];
                    pxl_vld_i = ($urandom_range(0, 3) != 0);
                end
            end else if (!pxl_vld_i) begin
                pxl_vld_i = 1'b1;
            end
        end
        if (pi < np) begin
            tests++; fails++;
            $display("FAIL stream_timeout got %0d pixels want %0d", pi, np);
        end
        pxl_vld_i = 1'b0; dbi_ctrl_mode_i = 2'd0; frame_pxl_i = '0;
        repeat (2) @(negedge clk);
        chk("stream_busy_clear", 64'(busy_o), 64'd0);
        chk("stream_sb_drain", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int np, amt;
        bit hr;
        logic [W-1:0] com;
        beat_t e;
        rst = 1'b1;
        dbi_ctrl_mode_i = '0; dbi_mem_com_i = '0; frame_pxl_i = '0; tx_type_hrst_i = 1'b0;
        tx_type_dat_amt_i = '0; tx_type_vld_i = 1'b0; tx_com_i = '0; tx_com_vld_i = 1'b0;
        tx_data_i = '0; tx_data_vld_i = 1'b0; pxl_d_i = '0; pxl_vld_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'(outs()), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        force_rdy = 1'b1;
        @(posedge clk); #1;
        cdat[0] = 8'h00; cdat[1] = 8'h01; cdat[2] = 8'hEF;
        do_conf(1'b0, 3, 8'h2A);
        do_conf(1'b0, 0, 8'h29);
        do_conf(1'b1, 0, 8'h01);
        do_conf(1'b0, 0, 8'h11);

        force_rdy = 1'b0;
        pix[0] = 16'hF800; pix[1] = 16'h07E0; pix[2] = 16'h001F;
        do_stream(3);

        // zero-length frame and mode 3 must leave the block idle
        dbi_ctrl_mode_i = 2'd2; pxl_vld_i = 1'b1; frame_pxl_i = '0;
        repeat (3) @(negedge clk);
        chk("zero_frame_idle", 64'(busy_o), 64'd0);
        dbi_ctrl_mode_i = 2'd3; tx_type_vld_i = 1'b1; frame_pxl_i = FW'(5);
        repeat (3) @(negedge clk);
        chk("mode3_idle", 64'(busy_o), 64'd0);
        dbi_ctrl_mode_i = 2'd0; tx_type_vld_i = 1'b0; pxl_vld_i = 1'b0; frame_pxl_i = '0;
        @(posedge clk); #1;

        // reset on the second beat of a frame
        force_rdy = 1'b1;
        @(posedge clk); #1;
        pix[0] = 16'hABCD;
        e.hrst = 1'b0; e.typ = 8'h2C; e.dat = 8'hAB; e.last = 1'b0; e.no_dat = 1'b0; e.strm = 1'b1;
        sb.push_back(e);
        dbi_mem_com_i = 8'h2C; frame_pxl_i = FW'(3); pxl_d_i = pix[0]; pxl_vld_i = 1'b1; dbi_ctrl_mode_i = 2'd2;
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_midframe_outputs", 64'(outs()), 64'd0);
        chk("rst_midframe_sb", 64'(sb.size()), 64'd0);
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        pix[0] = 16'h1234; pix[1] = 16'h5678; pix[2] = 16'h9ABC;
        do_stream(3);
        force_rdy = 1'b0;

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                hr = ($urandom_range(0, 5) == 0);
                amt = $urandom_range(0, 7);
                com = W'($urandom);
                for (int i = 0; i < 8; i++) cdat[i] = W'($urandom);
                do_conf(hr, amt, com);
            end else begin
                np = $urandom_range(1, 6);
                for (int i = 0; i < np; i++) pix[i] = (PB*W)'($urandom);
                do_stream(np);
            end
        end

        repeat (3) @(negedge clk);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
